// File: rtl/i2s_tx_sample_fifo.sv
// -----------------------------------------------------------------------------
// i2s_tx_sample_fifo
//   Stereo sample buffer feeding i2s_tx in the same iClk domain. The producer
//   writes left/right pairs over a valid/ready handshake. One pair is presented
//   per I2S frame, and the FIFO advances on each falling edge of iLRCLK.
//   A frame that starts while the FIFO is empty raises a one-cycle underrun pulse.
//
//   Optional build macro:
//     I2S_TX_FIFO_UNDERRUN_ZERO_EN  defined   -> underrun frames present silence (0)
//                                   undefined -> underrun frames repeat the last pair
//
// Parameters:
//   DATA_WIDTH  sample width per channel (must match i2s_tx)
//   FIFO_DEPTH  stored stereo pairs; power of 2, >= 2
//
// Ports:
//   iClk, iRstn              clock, asynchronous active-low reset
//   iWR_VALID, ivWR_LEFT,
//   ivWR_RIGHT, oWR_READY    producer write handshake
//   iLRCLK                   word clock from i2s_tx (already in iClk domain)
//   ovLEFT_DATA,
//   ovRIGHT_DATA             pair for the current frame, held between strobes
//   oUNDERRUN                one-cycle pulse: frame started with the FIFO empty
//   ovLEVEL                  number of stored pairs, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module i2s_tx_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          iClk,
  input  logic                          iRstn,
  input  logic                          iWR_VALID,
  input  logic [DATA_WIDTH-1:0]         ivWR_LEFT,
  input  logic [DATA_WIDTH-1:0]         ivWR_RIGHT,
  output logic                          oWR_READY,
  input  logic                          iLRCLK,
  output logic [DATA_WIDTH-1:0]         ovLEFT_DATA,
  output logic [DATA_WIDTH-1:0]         ovRIGHT_DATA,
  output logic                          oUNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0]   ovLEVEL
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // One stored stereo pair
  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } stereoPair_t;

  // Storage: parallel left/right arrays
  logic [DATA_WIDTH-1:0] rLeftMem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rRightMem [FIFO_DEPTH];

  logic [PTR_W-1:0] rWrPtr;
  logic [PTR_W-1:0] rRdPtr;
  logic             rLRCLK_d;

  logic             frameStrobe_c;
  logic             wrAccept_c;
  logic             popEn_c;
  logic             underrunHit_c;
  logic [LVL_W-1:0] levelNext_c;
  stereoPair_t      headPair_c;

  // Strobe, handshake and level bookkeeping
  always_comb begin
    frameStrobe_c = 1'b0;
    wrAccept_c    = 1'b0;
    popEn_c       = 1'b0;
    underrunHit_c = 1'b0;
    levelNext_c   = ovLEVEL;
    headPair_c    = '0;

    // Falling edge of the word clock marks the start of the left word
    frameStrobe_c = rLRCLK_d & ~iLRCLK;
    // Ready is registered, so there is no combinational path from iWR_VALID
    wrAccept_c    = iWR_VALID & oWR_READY;
    popEn_c       = frameStrobe_c & (ovLEVEL != '0);
    // A write in the strobe cycle is not bypassed; an empty FIFO still underruns
    underrunHit_c = frameStrobe_c & (ovLEVEL == '0);

    headPair_c.left  = rLeftMem[rRdPtr];
    headPair_c.right = rRightMem[rRdPtr];

    if (wrAccept_c && !popEn_c) begin
      levelNext_c = ovLEVEL + LVL_W'(1);
    end else if (!wrAccept_c && popEn_c) begin
      levelNext_c = ovLEVEL - LVL_W'(1);
    end
  end

  // Sample storage; contents need no reset because level gates visibility
  always_ff @(posedge iClk) begin
    if (wrAccept_c) begin
      rLeftMem[rWrPtr]  <= ivWR_LEFT;
      rRightMem[rWrPtr] <= ivWR_RIGHT;
    end
  end

  // Pointers, level, word-clock history and handshake flags
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rLRCLK_d  <= 1'b0;
      rWrPtr    <= '0;
      rRdPtr    <= '0;
      ovLEVEL   <= '0;
      oWR_READY <= 1'b1;
      oUNDERRUN <= 1'b0;
    end else begin
      rLRCLK_d  <= iLRCLK;
      ovLEVEL   <= levelNext_c;
      oWR_READY <= (levelNext_c != LVL_FULL);
      oUNDERRUN <= underrunHit_c;
      // Pointers wrap naturally since FIFO_DEPTH is a power of two
      if (wrAccept_c) begin
        rWrPtr <= rWrPtr + PTR_W'(1);
      end
      if (popEn_c) begin
        rRdPtr <= rRdPtr + PTR_W'(1);
      end
    end
  end

  // Frame output pair; changes only on a strobe
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      ovLEFT_DATA  <= '0;
      ovRIGHT_DATA <= '0;
    end else if (popEn_c) begin
      ovLEFT_DATA  <= headPair_c.left;
      ovRIGHT_DATA <= headPair_c.right;
    end else if (underrunHit_c) begin
`ifdef I2S_TX_FIFO_UNDERRUN_ZERO_EN
      // Silence for the starved frame
      ovLEFT_DATA  <= '0;
      ovRIGHT_DATA <= '0;
`else
      // Repeat the previously presented pair
      ovLEFT_DATA  <= ovLEFT_DATA;
      ovRIGHT_DATA <= ovRIGHT_DATA;
`endif
    end
  end

endmodule

// File: tb/tb_i2s_tx_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_sample_fifo
//   Directed stimulus with hand-computed expectations. Each driven frame
//   pushes its expected pair/underrun into a queue; the monitor pops the
//   queue on every frame strobe it observes and checks that the outputs
//   hold steady in between.
// -----------------------------------------------------------------------------
module tb_i2s_tx_sample_fifo;

`ifdef I2S_TX_FIFO_UNDERRUN_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic        iClk;
  logic        iRstn;
  logic        iWR_VALID;
  logic [31:0] ivWR_LEFT;
  logic [31:0] ivWR_RIGHT;
  logic        oWR_READY;
  logic        iLRCLK;
  logic [31:0] ovLEFT_DATA;
  logic [31:0] ovRIGHT_DATA;
  logic        oUNDERRUN;
  logic [3:0]  ovLEVEL;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        ur;
  } exp_t;

  exp_t expQ[$];
  int   vecs = 0;
  int   errs = 0;

  i2s_tx_sample_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .iClk        (iClk),
    .iRstn       (iRstn),
    .iWR_VALID   (iWR_VALID),
    .ivWR_LEFT   (ivWR_LEFT),
    .ivWR_RIGHT  (ivWR_RIGHT),
    .oWR_READY   (oWR_READY),
    .iLRCLK      (iLRCLK),
    .ovLEFT_DATA (ovLEFT_DATA),
    .ovRIGHT_DATA(ovRIGHT_DATA),
    .oUNDERRUN   (oUNDERRUN),
    .ovLEVEL     (ovLEVEL)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output pair an underrun frame should present, given what was shown before
  function automatic logic [31:0] urVal(input logic [31:0] prev);
    return ZERO_EN ? 32'h0 : prev;
  endfunction

  // Monitor: tracks the word clock itself and checks each frame strobe
  logic        lrPrev = 1'b0;
  logic        strobeSeen;
  logic [31:0] lastL = '0;
  logic [31:0] lastR = '0;
  exp_t        e;

  initial begin
    forever begin
      @(posedge iClk);
      strobeSeen = iRstn && lrPrev && !iLRCLK;
      lrPrev     = iRstn ? iLRCLK : 1'b0;
      #1;
      if (!iRstn) begin
        lastL = '0;
        lastR = '0;
        continue;
      end
      if (strobeSeen) begin
        if (expQ.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_strobe: no expectation queued at %0t", $time);
        end else begin
          e = expQ.pop_front();
          chk("frame_left", ovLEFT_DATA, e.l);
          chk("frame_right", ovRIGHT_DATA, e.r);
          chk("frame_underrun", 32'(oUNDERRUN), 32'(e.ur));
          lastL = e.l;
          lastR = e.r;
        end
      end else begin
        chk("idle_underrun", 32'(oUNDERRUN), 32'h0);
        chk("hold_left", ovLEFT_DATA, lastL);
        chk("hold_right", ovRIGHT_DATA, lastR);
      end
    end
  end

  // Single write, one cycle of iWR_VALID
  task automatic wr(input logic [31:0] l, input logic [31:0] r);
    @(negedge iClk);
    iWR_VALID  = 1'b1;
    ivWR_LEFT  = l;
    ivWR_RIGHT = r;
    @(negedge iClk);
    iWR_VALID  = 1'b0;
  endtask

  // One word-clock high/low pair; expectation queued as the clock falls
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input logic ur);
    exp_t x;
    @(negedge iClk);
    iLRCLK = 1'b1;
    @(negedge iClk);
    iLRCLK = 1'b0;
    x.l = l; x.r = r; x.ur = ur;
    expQ.push_back(x);
    @(negedge iClk);
  endtask

  task automatic chkLevel(input string name, input int lvl, input logic rdy);
    chk({name, "_level"}, 32'(ovLEVEL), 32'(lvl));
    chk({name, "_ready"}, 32'(oWR_READY), 32'(rdy));
  endtask

  initial begin
    exp_t x;
    iRstn      = 1'b0;
    iWR_VALID  = 1'b0;
    ivWR_LEFT  = '0;
    ivWR_RIGHT = '0;
    iLRCLK     = 1'b0;
    repeat (3) @(negedge iClk);
    iRstn = 1'b1;

    // Reset state, release with iLRCLK low
    chkLevel("reset", 0, 1'b1);
    chk("reset_left", ovLEFT_DATA, 32'h0);
    chk("reset_right", ovRIGHT_DATA, 32'h0);
    chk("reset_underrun", 32'(oUNDERRUN), 32'h0);
    repeat (4) @(negedge iClk);

    // Two pairs presented in order
    wr(32'hA5A5A5A5, 32'h5A5A5A5A);
    wr(32'h11111111, 32'h22222222);
    chkLevel("two_written", 2, 1'b1);
    frame(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    chkLevel("pop1", 1, 1'b1);
    frame(32'h11111111, 32'h22222222, 1'b0);
    chkLevel("pop2", 0, 1'b1);

    // Fill: 10 offered, first 8 accepted
    @(negedge iClk);
    for (int i = 0; i < 10; i++) begin
      iWR_VALID  = 1'b1;
      ivWR_LEFT  = 32'h100 + 32'(i);
      ivWR_RIGHT = 32'h200 + 32'(i);
      @(negedge iClk);
    end
    iWR_VALID = 1'b0;
    chkLevel("full", 8, 1'b0);
    frame(32'h100, 32'h200, 1'b0);
    chkLevel("pop_from_full", 7, 1'b1);
    wr(32'h1AA, 32'h2AA);
    chkLevel("refill_wrap", 8, 1'b0);
    for (int i = 1; i < 8; i++) begin
      frame(32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
    end
    frame(32'h1AA, 32'h2AA, 1'b0);
    chkLevel("drained", 0, 1'b1);

    // Underrun after presenting a known pair
    wr(32'h12345678, 32'h9ABCDEF0);
    frame(32'h12345678, 32'h9ABCDEF0, 1'b0);
    frame(urVal(32'h12345678), urVal(32'h9ABCDEF0), 1'b1);
    chkLevel("after_underrun", 0, 1'b1);
    frame(urVal(32'h12345678), urVal(32'h9ABCDEF0), 1'b1);

    // Write in the same cycle as a strobe on an empty FIFO: no bypass
    @(negedge iClk);
    iLRCLK = 1'b1;
    @(negedge iClk);
    iLRCLK     = 1'b0;
    iWR_VALID  = 1'b1;
    ivWR_LEFT  = 32'hC0FFEE01;
    ivWR_RIGHT = 32'hC0FFEE02;
    x.l = urVal(32'h12345678); x.r = urVal(32'h9ABCDEF0); x.ur = 1'b1;
    expQ.push_back(x);
    @(negedge iClk);
    iWR_VALID = 1'b0;
    chkLevel("same_cycle_write", 1, 1'b1);
    frame(32'hC0FFEE01, 32'hC0FFEE02, 1'b0);
    chkLevel("same_cycle_drained", 0, 1'b1);

    // Mid-frame asynchronous reset with five pairs stored
    for (int i = 0; i < 6; i++) begin
      wr(32'h51 + 32'(i), 32'h61 + 32'(i));
    end
    frame(32'h51, 32'h61, 1'b0);
    chkLevel("pre_reset", 5, 1'b1);
    @(posedge iClk);
    #2;
    iRstn = 1'b0;
    #1;
    chkLevel("async_reset", 0, 1'b1);
    chk("async_reset_left", ovLEFT_DATA, 32'h0);
    chk("async_reset_right", ovRIGHT_DATA, 32'h0);
    @(negedge iClk);
    @(negedge iClk);
    iRstn = 1'b1;
    repeat (2) @(negedge iClk);
    // Old pairs are gone: the next frame underruns from the reset value
    frame(32'h0, 32'h0, 1'b1);
    chkLevel("post_reset", 0, 1'b1);
    wr(32'h77, 32'h88);
    frame(32'h77, 32'h88, 1'b0);
    chkLevel("post_reset_drained", 0, 1'b1);

    // Bounded drain of outstanding expectations
    for (int k = 0; k < 50 && expQ.size() != 0; k++) @(negedge iClk);
    if (expQ.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL pending_frames: %0d expected frames never observed", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sample_fifo.md
# i2s_tx_sample_fifo

Stereo sample buffer sitting directly upstream of `i2s_tx`, in the same `iClk` domain. Accepts left/right sample pairs from a producer over a valid/ready handshake, stores up to `FIFO_DEPTH` pairs, and presents one pair on `ovLEFT_DATA`/`ovRIGHT_DATA` per I2S frame. The FIFO advances on each falling edge of the `oLRCLK` that `i2s_tx` generates. It flags an underrun when a frame starts with the FIFO empty.

## Interface
Parameters:
- `DATA_WIDTH`, 32: sample width per channel; must match `i2s_tx`.
- `FIFO_DEPTH`, 8: number of stereo pairs stored; power of 2, ≥2.

Ports:
- `iClk`  in  1  system clock; same clock as `i2s_tx`.
- `iRstn`  in  1  reset, asynchronous, active-low.
- `iWR_VALID`  in  1  producer has a pair on `ivWR_LEFT`/`ivWR_RIGHT`.
- `ivWR_LEFT`  in  DATA_WIDTH  left sample to write.
- `ivWR_RIGHT`  in  DATA_WIDTH  right sample to write.
- `oWR_READY`  out  1  FIFO can accept a pair; equals level != FIFO_DEPTH.
- `iLRCLK`  in  1  word clock from `i2s_tx` `oLRCLK`; already in the `iClk` domain, not resynchronised.
- `ovLEFT_DATA`  out  DATA_WIDTH  current-frame left sample, to `i2s_tx` `ivLEFT_DATA`.
- `ovRIGHT_DATA`  out  DATA_WIDTH  current-frame right sample, to `i2s_tx` `ivRIGHT_DATA`.
- `oUNDERRUN`  out  1  one-cycle pulse: a frame started with the FIFO empty.
- `ovLEVEL`  out  clog2(FIFO_DEPTH)+1  number of stored pairs, 0..FIFO_DEPTH.

## Operation
- Storage: two parallel arrays, left and right, each `FIFO_DEPTH` × `DATA_WIDTH`. The write pointer and read pointer are each clog2(FIFO_DEPTH) bits and wrap modulo `FIFO_DEPTH`. The level counter is kept separately.
- Write: when `iWR_VALID && oWR_READY` at a rising edge of `iClk`:
  - the pair is stored at the write pointer;
  - the write pointer increments.
- Frame strobe: `rLRCLK_d` is `iLRCLK` registered. The strobe is `rLRCLK_d & ~iLRCLK`, i.e. a falling edge (start of the left word).
- On the strobe with level > 0:
  - the pair at the read pointer is loaded into `ovLEFT_DATA`/`ovRIGHT_DATA`;
  - the read pointer increments.
- On the strobe with level == 0:
  - `oUNDERRUN` pulses high for one cycle;
  - the read pointer is unchanged;
  - the outputs follow the Configuration rule.
- Level update per cycle:
  - write only: +1;
  - pop only: −1;
  - write and pop together: unchanged.
- Write to an empty FIFO in the same cycle as the strobe: no bypass. The strobe underruns, the write is stored, and level becomes 1.
- Strobe while full: the pop proceeds and `oWR_READY` rises the next cycle. A write cannot be accepted in the strobe cycle itself, because `oWR_READY` was 0.
- No state machine beyond the pointers and level. The outputs are held between strobes and change only on a strobe.

## Timing
- Reset values (`iRstn`=0, asynchronous):
  - `ovLEFT_DATA` = 0, `ovRIGHT_DATA` = 0, `oUNDERRUN` = 0, `ovLEVEL` = 0;
  - both pointers 0, `rLRCLK_d` = 0;
  - `oWR_READY` = 1 (level 0).
- Since `rLRCLK_d` resets to 0, no spurious strobe occurs if `iLRCLK` is low at release. The first strobe is the first real falling edge after release.
- Write latency: a pair accepted at edge N is counted in `ovLEVEL` after edge N. It can be popped by a strobe at edge N+1 or later.
- Pop latency: `iLRCLK` falls before edge N, so the strobe is high during the cycle ending at edge N. New `ovLEFT_DATA`/`ovRIGHT_DATA` are valid after edge N and stable for the whole frame.
- `oUNDERRUN` is registered and high for exactly the cycle after edge N.
- Reset asserted mid-frame: all stored pairs are discarded and the outputs return to 0 immediately.
- `oWR_READY` and `ovLEVEL` are registered-derived; there is no combinational path from `iWR_VALID`.

## Configuration
- `I2S_TX_FIFO_UNDERRUN_ZERO_EN` defined: on underrun, `ovLEFT_DATA` and `ovRIGHT_DATA` load 0 (silence) for that frame.
- Undefined: on underrun, both outputs hold the previously presented pair (repeat last sample).
- `oUNDERRUN` behaves identically in both builds.

## Test plan
- Reset, then release with `iLRCLK` low → no `oUNDERRUN` before the first falling edge; outputs 0, `ovLEVEL`=0, `oWR_READY`=1.
- Write pairs (L,R) = (0xA5A5A5A5, 0x5A5A5A5A) and (0x11111111, 0x22222222); drive two `iLRCLK` falling edges → the outputs present each pair in order, one edge-cycle after each fall; `ovLEVEL` goes 2 → 1 → 0.
- Hold `iWR_VALID`=1 with incrementing data and no `iLRCLK` edges → exactly 8 pairs accepted; `oWR_READY`=0 with `ovLEVEL`=8. One falling edge → `ovLEVEL`=7 and `oWR_READY`=1 the next cycle; the 9th pair is then accepted and popped 8th later (pointer wrap).
- Falling edge with the FIFO empty after presenting 0x12345678/0x9ABCDEF0 → `oUNDERRUN` pulses one cycle. Outputs become 0 with `I2S_TX_FIFO_UNDERRUN_ZERO_EN` defined; they stay 0x12345678/0x9ABCDEF0 without it.
- Write accepted in the same cycle as the strobe on an empty FIFO → underrun pulse, `ovLEVEL`=1; the pair appears at the next falling edge.
- Assert `iRstn` low mid-frame with `ovLEVEL`=5 → outputs 0 and `ovLEVEL`=0 asynchronously; after release the old data never reappears.
